// File: rtl/module_keypad_scan.sv
// -----------------------------------------------------------------------------
// module_keypad_scan
//   4x4 matrix keypad scanner. Rotates an active-low column strobe, samples the
//   active-low rows through a 2-FF synchronizer, debounces press and release,
//   and emits one single-cycle rdy pulse with a stable key_code per accepted
//   keypress.
//
//   Optional feature: define KP_REPEAT_EN to build an auto-repeat counter that
//   re-emits the held key every REPEAT_CYCLES cycles.
//
// Ports
//   clk          in   1  system clock
//   rst          in   1  asynchronous active-low reset
//   row_i        in   4  keypad rows, active-low, asynchronous to clk
//   col_o        out  4  keypad columns, active-low one-hot
//   key_code     out  4  last accepted key, row_idx*4 + col_idx
//   rdy          out  1  one-cycle pulse, key_code is new
//   key_pressed  out  1  high from accept until release is debounced
// -----------------------------------------------------------------------------
module module_keypad_scan #(
    parameter int unsigned SCAN_DIV        = 16,
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned REPEAT_CYCLES   = 5000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_i,
    output logic [3:0] col_o,
    output logic [3:0] key_code,
    output logic       rdy,
    output logic       key_pressed
);

    localparam int unsigned DIV_W = $clog2(SCAN_DIV) + 1;
    localparam int unsigned DB_W  = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [2:0] {
        StScan,
        StDebounce,
        StEmit,
        StHeld,
        StRelDb
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [3:0]        r_sync1, r_row_s;
    logic [DIV_W-1:0]  r_div, w_div_nxt;
    logic [1:0]        r_col_idx, w_col_nxt;
    logic [1:0]        r_row_idx, w_row_idx_nxt;
    logic [3:0]        r_pat, w_pat_nxt;
    logic [DB_W-1:0]   r_db_cnt, w_db_nxt;
    logic [3:0]        r_key_code, w_code_nxt;
    logic              r_key_pressed, w_kp_nxt;
    logic [1:0]        w_low_row;

`ifdef KP_REPEAT_EN
    localparam int unsigned REP_W = $clog2(REPEAT_CYCLES) + 1;
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);
    logic [REP_W-1:0] r_rep_cnt, w_rep_nxt;
`else
    logic w_unused_repeat;
    assign w_unused_repeat = ^REPEAT_CYCLES;
`endif

    // Lowest-index low row wins when several rows are low.
    always_comb begin
        w_low_row = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!r_row_s[i]) w_low_row = 2'(i);
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_div_nxt     = r_div;
        w_col_nxt     = r_col_idx;
        w_row_idx_nxt = r_row_idx;
        w_pat_nxt     = r_pat;
        w_db_nxt      = r_db_cnt;
        w_code_nxt    = r_key_code;
        w_kp_nxt      = r_key_pressed;
`ifdef KP_REPEAT_EN
        w_rep_nxt     = r_rep_cnt;
`endif
        unique case (r_state)
            StScan: begin
                if (r_row_s != 4'hF) begin
                    // Column freezes; the latched column is r_col_idx itself.
                    w_row_idx_nxt = w_low_row;
                    w_pat_nxt     = r_row_s;
                    w_db_nxt      = '0;
                    w_div_nxt     = '0;
                    w_state_nxt   = StDebounce;
                end else if (r_div == DIV_LAST) begin
                    w_div_nxt = '0;
                    w_col_nxt = r_col_idx + 2'd1;
                end else begin
                    w_div_nxt = r_div + 1'b1;
                end
            end
            StDebounce: begin
                if (r_row_s != r_pat) begin
                    w_db_nxt    = '0;
                    w_state_nxt = StScan;
                end else if (r_db_cnt == DB_LAST) begin
                    w_db_nxt    = '0;
                    w_code_nxt  = {r_row_idx, r_col_idx};
                    w_kp_nxt    = 1'b1;
                    w_state_nxt = StEmit;
                end else begin
                    w_db_nxt = r_db_cnt + 1'b1;
                end
            end
            StEmit: begin
`ifdef KP_REPEAT_EN
                w_rep_nxt = '0;
`endif
                w_state_nxt = StHeld;
            end
            StHeld: begin
                if (r_row_s == 4'hF) begin
                    w_db_nxt    = '0;
                    w_state_nxt = StRelDb;
                end
`ifdef KP_REPEAT_EN
                else if (r_rep_cnt == REP_LAST) begin
                    w_rep_nxt   = '0;
                    w_state_nxt = StEmit;
                end else begin
                    w_rep_nxt = r_rep_cnt + 1'b1;
                end
`endif
            end
            StRelDb: begin
                if (r_row_s != 4'hF) begin
                    w_state_nxt = StHeld;
                end else if (r_db_cnt == DB_LAST) begin
                    w_db_nxt    = '0;
                    w_div_nxt   = '0;
                    w_kp_nxt    = 1'b0;
                    w_state_nxt = StScan;
                end else begin
                    w_db_nxt = r_db_cnt + 1'b1;
                end
            end
            default: w_state_nxt = StScan;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= StScan;
            r_sync1       <= 4'hF;
            r_row_s       <= 4'hF;
            r_div         <= '0;
            r_col_idx     <= 2'd0;
            r_row_idx     <= 2'd0;
            r_pat         <= 4'hF;
            r_db_cnt      <= '0;
            r_key_code    <= 4'd0;
            r_key_pressed <= 1'b0;
`ifdef KP_REPEAT_EN
            r_rep_cnt     <= '0;
`endif
        end else begin
            r_state       <= w_state_nxt;
            r_sync1       <= row_i;
            r_row_s       <= r_sync1;
            r_div         <= w_div_nxt;
            r_col_idx     <= w_col_nxt;
            r_row_idx     <= w_row_idx_nxt;
            r_pat         <= w_pat_nxt;
            r_db_cnt      <= w_db_nxt;
            r_key_code    <= w_code_nxt;
            r_key_pressed <= w_kp_nxt;
`ifdef KP_REPEAT_EN
            r_rep_cnt     <= w_rep_nxt;
`endif
        end
    end

    assign col_o       = ~(4'b0001 << r_col_idx);
    assign key_code    = r_key_code;
    assign rdy         = (r_state == StEmit);
    assign key_pressed = r_key_pressed;

endmodule
